// File: rtl/sp_mul_stream.sv
// sp_mul_stream: valid/ready stream wrapper around the platform multiplier.
//
// Accepts operand pairs on an input stream and runs one multiply at a time
// through an internal sp_mul_plat. It rounds the product half-up, removes
// FRAC fractional bits and returns the result on an output stream.
//
// Optional build macro: SP_MUL_STREAM_SIGNED_EN
//   When defined, operands are two's complement and rounding is half away
//   from zero. When undefined, all values are unsigned.
//
// sp_mul_plat ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start_in         one-cycle start pulse; operands sampled with it
//   a_in, b_in       WIDTH-bit unsigned operands
//   ready_out        low from the cycle after start_in until p_out is valid
//   p_out            product; holds until the next start_in
//
// sp_mul_stream ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   a_in, b_in       WIDTH-bit operands
//   in_valid         operand pair valid
//   in_ready         pair accepted this cycle (combinational)
//   c_out            OUTPUT_WIDTH-bit result, stable while out_valid is high
//   out_valid        result valid
//   out_ready        consumer takes the result

// Shift-add multiplier: consumes SHIFT bits of b per cycle.
// Latency from start_in to ready_out is ceil(WIDTH/SHIFT)+1 cycles.
module sp_mul_plat #(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned SHIFT        = 1,
  parameter int unsigned OUTPUT_WIDTH = 2 * WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start_in,
  input  logic [WIDTH-1:0]        a_in,
  input  logic [WIDTH-1:0]        b_in,
  output logic                    ready_out,
  output logic [OUTPUT_WIDTH-1:0] p_out
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned STEPS = (WIDTH + SHIFT - 1) / SHIFT;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  logic             r_busy;
  logic             r_ready;
  logic [CNT_W-1:0] r_cnt;
  logic [PW-1:0]    r_a_sh;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    w_partial;

  assign w_partial = PW'(r_a_sh * PW'(r_b[SHIFT-1:0]));

  // One partial product accumulated per busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
      r_cnt   <= '0;
      r_a_sh  <= '0;
      r_b     <= '0;
      r_acc   <= '0;
    end else if (start_in) begin
      r_busy  <= 1'b1;
      r_ready <= 1'b0;
      r_cnt   <= '0;
      r_a_sh  <= PW'(a_in);
      r_b     <= b_in;
      r_acc   <= '0;
    end else if (r_busy) begin
      r_acc  <= r_acc + w_partial;
      r_a_sh <= r_a_sh << SHIFT;
      r_b    <= r_b >> SHIFT;
      r_cnt  <= r_cnt + CNT_W'(1);
      if (r_cnt == CNT_W'(STEPS - 1)) begin
        r_busy  <= 1'b0;
        r_ready <= 1'b1;
      end
    end
  end

  assign ready_out = r_ready;
  assign p_out     = OUTPUT_WIDTH'(r_acc);

endmodule

module sp_mul_stream #(
  parameter int unsigned WIDTH        = 24,
  parameter int unsigned SHIFT        = 1,
  parameter int unsigned FRAC         = 0,
  parameter int unsigned OUTPUT_WIDTH = WIDTH * 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        a_in,
  input  logic [WIDTH-1:0]        b_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [OUTPUT_WIDTH-1:0] c_out,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned SUM_W  = PW + 1;
  localparam int unsigned EXT_W  = (OUTPUT_WIDTH > SUM_W) ? OUTPUT_WIDTH : SUM_W;
  localparam int unsigned RND_SH = (FRAC > 0) ? (FRAC - 1) : 0;
  localparam logic [SUM_W-1:0] RND = (FRAC > 0) ? (SUM_W'(1) << RND_SH) : '0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WIDTH-1:0]        r_a;
  logic [WIDTH-1:0]        r_b;
  logic                    r_start;
  logic                    r_first;
  logic                    r_out_valid;
  logic [OUTPUT_WIDTH-1:0] r_c;

  logic                    w_load;
  logic                    w_cap;
  logic                    w_start_nxt;
  logic                    w_first_nxt;
  logic                    w_valid_nxt;

  logic [WIDTH-1:0]        w_a_mag;
  logic [WIDTH-1:0]        w_b_mag;
  logic                    w_plat_ready;
  logic [PW-1:0]           w_p;
  logic [SUM_W-1:0]        w_sum;
  logic [SUM_W-1:0]        w_r;
  logic [EXT_W-1:0]        w_r_ext;
  logic [EXT_W-1:0]        w_res;

`ifdef SP_MUL_STREAM_SIGNED_EN
  logic r_sign;
  logic w_sign_in;

  // Magnitudes fit WIDTH unsigned bits, including -2^(WIDTH-1).
  assign w_a_mag   = a_in[WIDTH-1] ? (-a_in) : a_in;
  assign w_b_mag   = b_in[WIDTH-1] ? (-b_in) : b_in;
  assign w_sign_in = a_in[WIDTH-1] ^ b_in[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
    end else if (w_load) begin
      r_sign <= w_sign_in;
    end
  end
`else
  assign w_a_mag = a_in;
  assign w_b_mag = b_in;
`endif

  sp_mul_plat #(
    .WIDTH       (WIDTH),
    .SHIFT       (SHIFT),
    .OUTPUT_WIDTH(PW)
  ) u_plat (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_in (r_start),
    .a_in     (r_a),
    .b_in     (r_b),
    .ready_out(w_plat_ready),
    .p_out    (w_p)
  );

  // Round half-up on the magnitude, then drop FRAC bits.
  assign w_sum   = SUM_W'(w_p) + RND;
  assign w_r     = w_sum >> FRAC;
  assign w_r_ext = EXT_W'(w_r);

`ifdef SP_MUL_STREAM_SIGNED_EN
  assign w_res = r_sign ? (-w_r_ext) : w_r_ext;
`else
  assign w_res = w_r_ext;
`endif

  // Next-state, handshake and register-enable decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cap       = 1'b0;
    w_start_nxt = 1'b0;
    w_first_nxt = 1'b0;
    w_valid_nxt = r_out_valid;
    in_ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load      = 1'b1;
          w_start_nxt = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_first_nxt = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // ready_out may still be stale in the first wait cycle.
        if (!r_first && w_plat_ready) begin
          w_cap       = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        in_ready = out_ready;
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          if (in_valid) begin
            w_load      = 1'b1;
            w_start_nxt = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_start     <= 1'b0;
      r_first     <= 1'b0;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_c         <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_start     <= w_start_nxt;
      r_first     <= w_first_nxt;
      r_out_valid <= w_valid_nxt;
      if (w_load) begin
        r_a <= w_a_mag;
        r_b <= w_b_mag;
      end
      if (w_cap) begin
        r_c <= OUTPUT_WIDTH'(w_res);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign c_out     = r_c;

endmodule

// File: tb/tb_sp_mul_stream.sv
// Testbench for sp_mul_stream: two instances (FRAC=0 and FRAC=4, WIDTH=8),
// directed vectors with expected results queued at acceptance and checked by
// per-instance monitors on each output handshake.
module tb_sp_mul_stream;

  localparam int unsigned W   = 8;
  localparam int unsigned OW  = 16;
  localparam int unsigned LAT = 9;   // WIDTH=8, SHIFT=1: 8 steps + 1

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0]  a0, b0, a4, b4;
  logic          iv0, ir0, ov0, or0;
  logic          iv4, ir4, ov4, or4;
  logic [OW-1:0] c0, c4;

  logic [OW-1:0] q0[$];
  logic [OW-1:0] q4[$];

  sp_mul_stream #(.WIDTH(W), .SHIFT(1), .FRAC(0), .OUTPUT_WIDTH(OW)) u0 (
    .clk(clk), .rst_n(rst_n), .a_in(a0), .b_in(b0), .in_valid(iv0),
    .in_ready(ir0), .c_out(c0), .out_valid(ov0), .out_ready(or0)
  );

  sp_mul_stream #(.WIDTH(W), .SHIFT(1), .FRAC(4), .OUTPUT_WIDTH(OW)) u4 (
    .clk(clk), .rst_n(rst_n), .a_in(a4), .b_in(b4), .in_valid(iv4),
    .in_ready(ir4), .c_out(c4), .out_valid(ov4), .out_ready(or4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor for u0: pops on handshake, checks stability while stalled.
  logic          pv0, pr0;
  logic [OW-1:0] pc0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv0 = 1'b0;
      pr0 = 1'b0;
    end else begin
      if (pv0 && !pr0) begin
        check("u0_hold_valid", 32'(ov0), 32'd1);
        check("u0_hold_stable", 32'(c0), 32'(pc0));
      end
      if (ov0 && or0) begin
        if (q0.size() == 0) check("u0_unexpected_result", 32'(c0), 32'hFFFF_FFFF);
        else check("u0_result", 32'(c0), 32'(q0.pop_front()));
      end
      pv0 = ov0;
      pr0 = or0;
      pc0 = c0;
    end
  end

  // Monitor for u4.
  logic          pv4, pr4;
  logic [OW-1:0] pc4;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv4 = 1'b0;
      pr4 = 1'b0;
    end else begin
      if (pv4 && !pr4) begin
        check("u4_hold_valid", 32'(ov4), 32'd1);
        check("u4_hold_stable", 32'(c4), 32'(pc4));
      end
      if (ov4 && or4) begin
        if (q4.size() == 0) check("u4_unexpected_result", 32'(c4), 32'hFFFF_FFFF);
        else check("u4_result", 32'(c4), 32'(q4.pop_front()));
      end
      pv4 = ov4;
      pr4 = or4;
      pc4 = c4;
    end
  end

  // Present a pair to instance sel (0 or 4); returns at acceptance edge + 1.
  task automatic send(input int sel, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [OW-1:0] e, input bit push, input bit keep,
                      output int acc_cyc);
    int  n;
    bit  rdy;
    if (sel == 0) begin a0 = a; b0 = b; iv0 = 1'b1; end
    else          begin a4 = a; b4 = b; iv4 = 1'b1; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rdy = (sel == 0) ? ir0 : ir4;
    end while (!rdy && n < 100);
    if (!rdy) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    if (push) begin
      if (sel == 0) q0.push_back(e);
      else          q4.push_back(e);
    end
    #1;
    acc_cyc = cyc;
    // Scramble operand inputs so held operands are what gets multiplied.
    if (sel == 0) begin a0 = ~a; b0 = ~b; if (!keep) iv0 = 1'b0; end
    else          begin a4 = ~a; b4 = ~b; if (!keep) iv4 = 1'b0; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(q0.size() == 0 && q4.size() == 0 && !ov0 && !ov4) && n < 200);
    if (n >= 200) check("drain_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, c2, c3, n;
    rst_n = 1'b0;
    a0 = '0; b0 = '0; iv0 = 1'b0; or0 = 1'b1;
    a4 = '0; b4 = '0; iv4 = 1'b0; or4 = 1'b1;
    #1;
    check("rst_out_valid0", 32'(ov0), 32'd0);
    check("rst_c_out0", 32'(c0), 32'd0);
    check("rst_in_ready0", 32'(ir0), 32'd1);
    check("rst_out_valid4", 32'(ov4), 32'd0);
    check("rst_c_out4", 32'(c4), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 3*5 with latency and in_ready profile.
    send(0, 8'd3, 8'd5, 16'h000F, 1'b1, 1'b0, c1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!ov0) check("busy_in_ready0", 32'(ir0), 32'd0);
    end while (!ov0 && n < 40);
    check("latency0", 32'(n), 32'(LAT + 2));
    drain();

    // 255*255 stalled by the consumer for 10 cycles.
    or0 = 1'b0;
`ifdef SP_MUL_STREAM_SIGNED_EN
    send(0, 8'hFF, 8'hFF, 16'h0001, 1'b1, 1'b0, c1);
`else
    send(0, 8'hFF, 8'hFF, 16'hFE01, 1'b1, 1'b0, c1);
`endif
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ov0 && n < 40);
    check("stall_valid_rise", 32'(ov0), 32'd1);
    repeat (10) begin
      @(negedge clk);
      check("stall_in_ready0", 32'(ir0), 32'd0);
    end
    @(posedge clk);
    #1 or0 = 1'b1;
    drain();

    // Back-to-back through HOLD: acceptances L+2 cycles apart.
    send(0, 8'd3, 8'd5, 16'd15, 1'b1, 1'b1, c1);
    send(0, 8'd5, 8'd7, 16'd35, 1'b1, 1'b1, c2);
    send(0, 8'd7, 8'd9, 16'd63, 1'b1, 1'b0, c3);
    check("b2b_gap1", 32'(c2 - c1), 32'(LAT + 2));
    check("b2b_gap2", 32'(c3 - c2), 32'(LAT + 2));
    drain();

    // FRAC=4 rounding.
    send(4, 8'd7, 8'd3, 16'd1, 1'b1, 1'b0, c1);
    send(4, 8'd8, 8'd3, 16'd2, 1'b1, 1'b0, c1);
`ifdef SP_MUL_STREAM_SIGNED_EN
    send(4, 8'hFF, 8'hFF, 16'h0000, 1'b1, 1'b0, c1);
    send(4, 8'hF9, 8'd3, 16'hFFFF, 1'b1, 1'b0, c1);
`else
    send(4, 8'hFF, 8'hFF, 16'h0FE0, 1'b1, 1'b0, c1);
`endif
    drain();

`ifdef SP_MUL_STREAM_SIGNED_EN
    send(0, 8'hFD, 8'd5, 16'hFFF1, 1'b1, 1'b0, c1);
    send(0, 8'h80, 8'h80, 16'h4000, 1'b1, 1'b0, c1);
    drain();
`endif

    // Reset during WAIT abandons the multiply.
    send(0, 8'd9, 8'd9, 16'd0, 1'b0, 1'b0, c1);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid0", 32'(ov0), 32'd0);
    check("midrst_c_out0", 32'(c0), 32'd0);
    check("midrst_in_ready0", 32'(ir0), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 8'd2, 8'd2, 16'd4, 1'b1, 1'b0, c1);
    drain();
    repeat (3) @(negedge clk);
    check("final_out_valid0", 32'(ov0), 32'd0);
    check("queue0_empty", 32'(q0.size()), 32'd0);
    check("queue4_empty", 32'(q4.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
